// File: rtl/ctrl_pkg.sv
// Shared constants and types for the miniRV decode / hazard control slice.
package ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_DRAM = 2'd1;
  localparam logic [1:0] WSEL_PC4  = 2'd2;
  localparam logic [1:0] WSEL_EXT  = 2'd3;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic ALUA_RS1 = 1'b0;
  localparam logic ALUA_PC  = 1'b1;
  localparam logic ALUB_RS2 = 1'b0;
  localparam logic ALUB_EXT = 1'b1;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_WB    = 2'd3;

  localparam logic [2:0] BR_BTYPE = 3'b100;
  localparam logic [2:0] BR_JAL   = 3'b010;
  localparam logic [2:0] BR_JALR  = 3'b001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic [3:0] alu_op;
    logic       alua_sel;
    logic       alub_sel;
    logic       ram_we;
    logic [2:0] br;
  } ctrl_bundle_t;

  typedef struct packed {
    logic       valid;
    logic       rf_we;
    logic [4:0] rd;
    logic       is_load;
  } trk_t;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // x0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic trk_hit(input trk_t t, input logic used, input logic [4:0] rs);
    return used & t.valid & t.rf_we & (t.rd != 5'd0) & (t.rd == rs);
  endfunction

endpackage

// File: rtl/ctrl_hazard_unit_if.sv
// Pipeline-side connection of the hazard unit: ID instruction in, stall/flush and EX control out.
interface ctrl_hazard_unit_if;
  logic [31:0] id_inst_i;
  logic        id_valid_i;
  logic        ex_br_taken_i;
  logic [2:0]  id_sext_op_o;
  logic        stall_pc_o;
  logic        stall_ifid_o;
  logic        flush_ifid_o;
  logic        ex_rf_we_o;
  logic [1:0]  ex_rf_wsel_o;
  logic [3:0]  ex_alu_op_o;
  logic        ex_alua_sel_o;
  logic        ex_alub_sel_o;
  logic        ex_ram_we_o;
  logic [2:0]  ex_br_o;
  logic [1:0]  ex_fwd_a_o;
  logic [1:0]  ex_fwd_b_o;

  modport master (
    output id_inst_i, id_valid_i, ex_br_taken_i,
    input  id_sext_op_o, stall_pc_o, stall_ifid_o, flush_ifid_o,
    input  ex_rf_we_o, ex_rf_wsel_o, ex_alu_op_o, ex_alua_sel_o, ex_alub_sel_o,
    input  ex_ram_we_o, ex_br_o, ex_fwd_a_o, ex_fwd_b_o
  );

  modport slave (
    input  id_inst_i, id_valid_i, ex_br_taken_i,
    output id_sext_op_o, stall_pc_o, stall_ifid_o, flush_ifid_o,
    output ex_rf_we_o, ex_rf_wsel_o, ex_alu_op_o, ex_alua_sel_o, ex_alub_sel_o,
    output ex_ram_we_o, ex_br_o, ex_fwd_a_o, ex_fwd_b_o
  );
endinterface

// File: rtl/inst_decoder.sv
// Combinational opcode/funct3/funct7 decode of one RV32I word into the control bundle.
module inst_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  inst_i,
  output ctrl_bundle_t ctrl_o,
  output logic [2:0]   sext_op_o,
  output logic         use_rs1_o,
  output logic         use_rs2_o,
  output logic         is_load_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign f7b5        = inst_i[30];
  assign unused_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  always_comb begin
    ctrl_o    = '0;
    sext_op_o = SEXT_I;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    is_load_o = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.alu_op = alu_from_f3(funct3, f7b5);
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.rf_we    = 1'b1;
        ctrl_o.alub_sel = ALUB_EXT;
        // funct7[5] only selects SRAI; for ADDI it is immediate bits.
        ctrl_o.alu_op   = alu_from_f3(funct3, (funct3 == 3'b101) & f7b5);
        use_rs1_o       = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.rf_we    = 1'b1;
        ctrl_o.rf_wsel  = WSEL_DRAM;
        ctrl_o.alub_sel = ALUB_EXT;
        use_rs1_o       = 1'b1;
        is_load_o       = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.ram_we   = 1'b1;
        ctrl_o.alub_sel = ALUB_EXT;
        sext_op_o       = SEXT_S;
        use_rs1_o       = 1'b1;
        use_rs2_o       = 1'b1;
      end
      OP_BRANCH: begin
        sext_op_o = SEXT_B;
        if (funct3[2:1] != 2'b01) begin
          ctrl_o.br = BR_BTYPE;
          use_rs1_o = 1'b1;
          use_rs2_o = 1'b1;
          case (funct3)
            3'b000:  ctrl_o.alu_op = ALU_BEQ;
            3'b001:  ctrl_o.alu_op = ALU_BNE;
            3'b100:  ctrl_o.alu_op = ALU_BLT;
            3'b101:  ctrl_o.alu_op = ALU_BGE;
            3'b110:  ctrl_o.alu_op = ALU_BLTU;
            default: ctrl_o.alu_op = ALU_BGEU;
          endcase
        end
      end
      OP_JAL: begin
        ctrl_o.rf_we   = 1'b1;
        ctrl_o.rf_wsel = WSEL_PC4;
        ctrl_o.br      = BR_JAL;
        sext_op_o      = SEXT_J;
      end
      OP_JALR: begin
        ctrl_o.rf_we    = 1'b1;
        ctrl_o.rf_wsel  = WSEL_PC4;
        ctrl_o.alub_sel = ALUB_EXT;
        ctrl_o.br       = BR_JALR;
        use_rs1_o       = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.rf_we   = 1'b1;
        ctrl_o.rf_wsel = WSEL_EXT;
        sext_op_o      = SEXT_U;
      end
      OP_AUIPC: begin
        ctrl_o.rf_we    = 1'b1;
        ctrl_o.alua_sel = ALUA_PC;
        ctrl_o.alub_sel = ALUB_EXT;
        sext_op_o       = SEXT_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// ID decode into the ID/EX control register, EX/MEM/WB destination tracking,
// stall/flush generation, forwarding selects and saturating hazard counters.
module ctrl_hazard_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned RF_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  ctrl_hazard_unit_if.slave pipe,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  ctrl_bundle_t id_ctrl;
  logic [2:0]   id_sext;
  logic         id_use_rs1, id_use_rs2, id_is_load;
  logic [4:0]   rs1, rs2, rd;

  inst_decoder u_dec (
    .inst_i    (pipe.id_inst_i),
    .ctrl_o    (id_ctrl),
    .sext_op_o (id_sext),
    .use_rs1_o (id_use_rs1),
    .use_rs2_o (id_use_rs2),
    .is_load_o (id_is_load)
  );

  assign rs1 = pipe.id_inst_i[19:15];
  assign rs2 = pipe.id_inst_i[24:20];
  assign rd  = pipe.id_inst_i[11:7];

  trk_t             ex_trk_q, mem_trk_q, wb_trk_q, ex_trk_d;
  ctrl_bundle_t     ex_ctrl_q;
  logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic u1, u2, a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic hazard, stall, flush, bubble;

  always_comb begin
    u1    = pipe.id_valid_i & id_use_rs1;
    u2    = pipe.id_valid_i & id_use_rs2;
    a_ex  = trk_hit(ex_trk_q,  u1, rs1);
    a_mem = trk_hit(mem_trk_q, u1, rs1);
    a_wb  = trk_hit(wb_trk_q,  u1, rs1);
    b_ex  = trk_hit(ex_trk_q,  u2, rs2);
    b_mem = trk_hit(mem_trk_q, u2, rs2);
    b_wb  = trk_hit(wb_trk_q,  u2, rs2);
    hazard  = 1'b0;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (FWD_EN != 0) begin
      hazard = (a_ex | b_ex) & ex_trk_q.is_load;
      // Youngest producer wins so the most recent value is forwarded.
      if (a_ex)                        fwd_a_d = FWD_EXMEM;
      else if (a_mem)                  fwd_a_d = FWD_MEMWB;
      else if (a_wb && RF_BYPASS == 0) fwd_a_d = FWD_WB;
      if (b_ex)                        fwd_b_d = FWD_EXMEM;
      else if (b_mem)                  fwd_b_d = FWD_MEMWB;
      else if (b_wb && RF_BYPASS == 0) fwd_b_d = FWD_WB;
    end else begin
      hazard = a_ex | b_ex | a_mem | b_mem | ((a_wb | b_wb) & (RF_BYPASS == 0));
    end
    flush    = pipe.ex_br_taken_i & ~cpu_rst;
    stall    = hazard & ~pipe.ex_br_taken_i & ~cpu_rst;
    bubble   = stall | pipe.ex_br_taken_i | ~pipe.id_valid_i;
    ex_trk_d = '{valid: 1'b1, rf_we: id_ctrl.rf_we, rd: rd, is_load: id_is_load};
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      ex_trk_q    <= '0;
      mem_trk_q   <= '0;
      wb_trk_q    <= '0;
      ex_ctrl_q   <= '0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_trk_q  <= mem_trk_q;
      mem_trk_q <= ex_trk_q;
      if (bubble) begin
        ex_trk_q  <= '0;
        ex_ctrl_q <= '0;
        fwd_a_q   <= '0;
        fwd_b_q   <= '0;
      end else begin
        ex_trk_q  <= ex_trk_d;
        ex_ctrl_q <= id_ctrl;
        fwd_a_q   <= fwd_a_d;
        fwd_b_q   <= fwd_b_d;
      end
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pipe.ex_br_taken_i && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign pipe.id_sext_op_o  = id_sext;
  assign pipe.stall_pc_o    = stall;
  assign pipe.stall_ifid_o  = stall;
  assign pipe.flush_ifid_o  = flush;
  assign pipe.ex_rf_we_o    = ex_ctrl_q.rf_we;
  assign pipe.ex_rf_wsel_o  = ex_ctrl_q.rf_wsel;
  assign pipe.ex_alu_op_o   = ex_ctrl_q.alu_op;
  assign pipe.ex_alua_sel_o = ex_ctrl_q.alua_sel;
  assign pipe.ex_alub_sel_o = ex_ctrl_q.alub_sel;
  assign pipe.ex_ram_we_o   = ex_ctrl_q.ram_we;
  assign pipe.ex_br_o       = ex_ctrl_q.br;
  assign pipe.ex_fwd_a_o    = fwd_a_q;
  assign pipe.ex_fwd_b_o    = fwd_b_q;
  assign stall_cnt_o        = stall_cnt_q;
  assign flush_cnt_o        = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_ctrl_hazard_unit;

  localparam logic [31:0] LW     = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD    = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] ADDI1  = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] ADDI2  = 32'h00108113; // addi x2,x1,1
  localparam logic [31:0] NOP    = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADDX0  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] ILL    = 32'hFFFFFFFF;
  localparam logic [31:0] AUIPC  = 32'h00001197; // auipc x3,1
  localparam logic [31:0] BGEU   = 32'h0020F063; // bgeu x1,x2,0
  localparam logic [31:0] SLT    = 32'h0020A3B3; // slt  x7,x1,x2

  typedef enum int unsigned {
    S_STALL_PC, S_STALL_IFID, S_FLUSH, S_RF_WE, S_WSEL, S_ALU_OP, S_ALUA, S_ALUB,
    S_RAM_WE, S_BR, S_FWD_A, S_FWD_B, S_SEXT, S_SCNT, S_FCNT
  } sig_e;

  typedef struct {
    int          cyc;
    int          dut;
    sig_e        sig;
    int unsigned val;
    string       tag;
  } exp_t;

  typedef struct packed {
    logic stall_pc, stall_ifid, flush, rf_we;
    logic [1:0] wsel;
    logic [3:0] alu_op;
    logic alua, alub, ram_we;
    logic [2:0] br;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] sext;
    logic [15:0] scnt, fcnt;
  } obs_t;

  logic clk, rst;
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  obs_t o0, o1;

  ctrl_hazard_unit_if ifa();
  ctrl_hazard_unit_if ifb();

  ctrl_hazard_unit #(.FWD_EN(1), .RF_BYPASS(1), .CNT_W(16)) u_fwd (
    .cpu_clk(clk), .cpu_rst(rst), .pipe(ifa), .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

  ctrl_hazard_unit #(.FWD_EN(0), .RF_BYPASS(1), .CNT_W(16)) u_stl (
    .cpu_clk(clk), .cpu_rst(rst), .pipe(ifb), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

  assign o0 = '{stall_pc: ifa.stall_pc_o, stall_ifid: ifa.stall_ifid_o, flush: ifa.flush_ifid_o,
                rf_we: ifa.ex_rf_we_o, wsel: ifa.ex_rf_wsel_o, alu_op: ifa.ex_alu_op_o,
                alua: ifa.ex_alua_sel_o, alub: ifa.ex_alub_sel_o, ram_we: ifa.ex_ram_we_o,
                br: ifa.ex_br_o, fwd_a: ifa.ex_fwd_a_o, fwd_b: ifa.ex_fwd_b_o,
                sext: ifa.id_sext_op_o, scnt: scnt0, fcnt: fcnt0};
  assign o1 = '{stall_pc: ifb.stall_pc_o, stall_ifid: ifb.stall_ifid_o, flush: ifb.flush_ifid_o,
                rf_we: ifb.ex_rf_we_o, wsel: ifb.ex_rf_wsel_o, alu_op: ifb.ex_alu_op_o,
                alua: ifb.ex_alua_sel_o, alub: ifb.ex_alub_sel_o, ram_we: ifb.ex_ram_we_o,
                br: ifb.ex_br_o, fwd_a: ifb.ex_fwd_a_o, fwd_b: ifb.ex_fwd_b_o,
                sext: ifb.id_sext_op_o, scnt: scnt1, fcnt: fcnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input obs_t o, input sig_e s);
    case (s)
      S_STALL_PC:   return 32'(o.stall_pc);
      S_STALL_IFID: return 32'(o.stall_ifid);
      S_FLUSH:      return 32'(o.flush);
      S_RF_WE:      return 32'(o.rf_we);
      S_WSEL:       return 32'(o.wsel);
      S_ALU_OP:     return 32'(o.alu_op);
      S_ALUA:       return 32'(o.alua);
      S_ALUB:       return 32'(o.alub);
      S_RAM_WE:     return 32'(o.ram_we);
      S_BR:         return 32'(o.br);
      S_FWD_A:      return 32'(o.fwd_a);
      S_FWD_B:      return 32'(o.fwd_b);
      S_SEXT:       return 32'(o.sext);
      S_SCNT:       return 32'(o.scnt);
      default:      return 32'(o.fcnt);
    endcase
  endfunction

  task automatic chk(input int d, input sig_e s, input int unsigned v, input string tag);
    exp_t e;
    e.cyc = cyc; e.dut = d; e.sig = s; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle_all();
    ifa.id_inst_i = '0; ifa.id_valid_i = 1'b0; ifa.ex_br_taken_i = 1'b0;
    ifb.id_inst_i = '0; ifb.id_valid_i = 1'b0; ifb.ex_br_taken_i = 1'b0;
  endtask

  task automatic drive(input int d, input logic [31:0] inst, input logic v, input logic br);
    @(posedge clk); #1;
    idle_all();
    if (d == 0) begin
      ifa.id_inst_i = inst; ifa.id_valid_i = v; ifa.ex_br_taken_i = br;
    end else begin
      ifb.id_inst_i = inst; ifb.id_valid_i = v; ifb.ex_br_taken_i = br;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every negedge, compare all expectations tagged for this cycle.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        got = pick(e.dut == 0 ? o0 : o1, e.sig);
        checks++;
        if (e.cyc != cyc || got !== 32'(e.val)) begin
          errors++;
          $display("FAIL %s dut%0d %s: got %0d required %0d (cycle %0d, sampled %0d)",
                   e.tag, e.dut, e.sig.name(), got, e.val, e.cyc, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    @(posedge clk); #1;
    chk(0, S_RF_WE, 0, "rst_rf_we");   chk(0, S_ALU_OP, 0, "rst_alu_op");
    chk(0, S_SCNT, 0, "rst_scnt");     chk(1, S_FCNT, 0, "rst_fcnt");
    chk(0, S_STALL_PC, 0, "rst_stall");
    @(posedge clk); #1;
    rst = 1'b0;

    // Load-use with forwarding: one stall, then MEM/WB forward on A.
    drive(0, LW, 1, 0);  chk(0, S_STALL_PC, 0, "lu_first"); chk(0, S_SEXT, 0, "lu_sext_i");
    drive(0, ADD, 1, 0); chk(0, S_STALL_PC, 1, "lu_stall_pc"); chk(0, S_STALL_IFID, 1, "lu_stall_ifid");
                         chk(0, S_WSEL, 1, "lu_ex_load");
    drive(0, ADD, 1, 0); chk(0, S_STALL_PC, 0, "lu_one_cycle"); chk(0, S_SCNT, 1, "lu_scnt");
                         chk(0, S_RF_WE, 0, "lu_bubble");
    drive(0, 0, 0, 0);   chk(0, S_RF_WE, 1, "lu_add_ex"); chk(0, S_FWD_A, 2, "lu_fwd_a");
                         chk(0, S_FWD_B, 0, "lu_fwd_b"); chk(0, S_SCNT, 1, "lu_scnt_hold");
    do_reset();

    // ALU result forwarded from EX/MEM without stalling.
    drive(0, ADDI1, 1, 0); chk(0, S_STALL_PC, 0, "af_first");
    drive(0, ADDI2, 1, 0); chk(0, S_STALL_PC, 0, "af_nostall"); chk(0, S_RF_WE, 1, "af_addi1_ex");
    drive(0, 0, 0, 0);     chk(0, S_FWD_A, 1, "af_fwd_a"); chk(0, S_ALUB, 1, "af_alub");
                           chk(0, S_ALU_OP, 0, "af_alu_add"); chk(0, S_SCNT, 0, "af_scnt");
    do_reset();

    // No forwarding network, register-file bypass: two stall cycles.
    drive(1, ADDI1, 1, 0); chk(1, S_STALL_PC, 0, "ns_first");
    drive(1, ADDI2, 1, 0); chk(1, S_STALL_PC, 1, "ns_stall_ex");
    drive(1, ADDI2, 1, 0); chk(1, S_STALL_PC, 1, "ns_stall_mem"); chk(1, S_SCNT, 1, "ns_scnt1");
    drive(1, ADDI2, 1, 0); chk(1, S_STALL_PC, 0, "ns_wb_bypass"); chk(1, S_SCNT, 2, "ns_scnt2");
                           chk(1, S_RF_WE, 0, "ns_bubble");
    drive(1, 0, 0, 0);     chk(1, S_RF_WE, 1, "ns_addi2_ex"); chk(1, S_FWD_A, 0, "ns_fwd_a");
                           chk(1, S_SCNT, 2, "ns_scnt_hold");
    do_reset();

    // Taken branch in the load-use stall cycle: flush wins.
    drive(0, LW, 1, 0);
    drive(0, ADD, 1, 1); chk(0, S_STALL_PC, 0, "fs_no_stall_pc"); chk(0, S_STALL_IFID, 0, "fs_no_stall_ifid");
                         chk(0, S_FLUSH, 1, "fs_flush"); chk(0, S_FCNT, 0, "fs_fcnt0");
    drive(0, 0, 0, 0);   chk(0, S_RF_WE, 0, "fs_bubble"); chk(0, S_FCNT, 1, "fs_fcnt1");
                         chk(0, S_SCNT, 0, "fs_scnt0"); chk(0, S_FLUSH, 0, "fs_flush_off");
    do_reset();

    // x0 never matches; illegal word becomes a bubble; extra decodes.
    drive(0, NOP, 1, 0);
    drive(0, ADDX0, 1, 0); chk(0, S_STALL_PC, 0, "x0_nostall"); chk(0, S_ALUB, 1, "x0_nop_alub");
    drive(0, ILL, 1, 0);   chk(0, S_FWD_A, 0, "x0_fwd_a"); chk(0, S_FWD_B, 0, "x0_fwd_b");
                           chk(0, S_RF_WE, 1, "x0_add_ex"); chk(0, S_ALUB, 0, "x0_add_alub");
    drive(0, AUIPC, 1, 0); chk(0, S_RF_WE, 0, "ill_rf_we"); chk(0, S_RAM_WE, 0, "ill_ram_we");
                           chk(0, S_BR, 0, "ill_br"); chk(0, S_ALU_OP, 0, "ill_alu");
                           chk(0, S_SEXT, 3, "auipc_sext");
    drive(0, BGEU, 1, 0);  chk(0, S_ALUA, 1, "auipc_alua"); chk(0, S_ALUB, 1, "auipc_alub");
                           chk(0, S_WSEL, 0, "auipc_wsel"); chk(0, S_RF_WE, 1, "auipc_we");
                           chk(0, S_SEXT, 2, "bgeu_sext");
    drive(0, SLT, 1, 0);   chk(0, S_ALU_OP, 15, "bgeu_alu"); chk(0, S_BR, 4, "bgeu_br");
                           chk(0, S_RF_WE, 0, "bgeu_we");
    drive(0, 0, 0, 0);     chk(0, S_ALU_OP, 8, "slt_alu"); chk(0, S_RF_WE, 1, "slt_we");
    do_reset();

    // Asynchronous reset in the middle of a load-use stall.
    drive(0, LW, 1, 0);
    drive(0, ADD, 1, 0);
    drive(0, ADD, 1, 0);
    drive(0, LW, 1, 0);   chk(0, S_SCNT, 1, "ar_pre_scnt"); chk(0, S_RF_WE, 1, "ar_pre_we");
    drive(0, ADD, 1, 0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ifa.stall_pc_o !== 1'b0 || ifa.stall_ifid_o !== 1'b0) begin
      errors++;
      $display("FAIL ar_direct_stall: stall outputs not 0 during reset");
    end
    checks++;
    if (ifa.ex_rf_we_o !== 1'b0) begin
      errors++;
      $display("FAIL ar_direct_rf_we: got %0b required 0", ifa.ex_rf_we_o);
    end
    checks++;
    if (ifa.ex_fwd_a_o !== 2'd0) begin
      errors++;
      $display("FAIL ar_direct_fwd_a: got %0d required 0", ifa.ex_fwd_a_o);
    end
    checks++;
    if (scnt0 !== 16'd0) begin
      errors++;
      $display("FAIL ar_direct_scnt: got %0d required 0", scnt0);
    end
    checks++;
    if (fcnt0 !== 16'd0) begin
      errors++;
      $display("FAIL ar_direct_fcnt: got %0d required 0", fcnt0);
    end
    chk(0, S_STALL_PC, 0, "ar_stall_pc"); chk(0, S_STALL_IFID, 0, "ar_stall_ifid");
    chk(0, S_FLUSH, 0, "ar_flush");       chk(0, S_RF_WE, 0, "ar_rf_we");
    chk(0, S_WSEL, 0, "ar_wsel");         chk(0, S_FWD_A, 0, "ar_fwd_a");
    chk(0, S_SCNT, 0, "ar_scnt");         chk(0, S_FCNT, 0, "ar_fcnt");
    @(posedge clk); #1;
    idle_all();
    rst = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s dut%0d %s: never sampled, required %0d", e.tag, e.dut, e.sig.name(), e.val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_hazard_unit.md
Name: ctrl_hazard_unit

Overview:
Decode-and-hazard control unit for the 5-stage miniRV pipeline. It decodes the ID-stage instruction into a control bundle and registers that bundle into the ID/EX boundary. It tracks in-flight destination registers for EX/MEM/WB, detects RAW, load-use and control hazards, and drives stall, flush and forwarding selects. It extends the single-cycle decoder with SLT/SLTU/SLTI/SLTIU, BLTU/BGEU and AUIPC, and adds saturating hazard counters.

Parameters:
FWD_EN, 1, 1 = forwarding network present; 0 = resolve every RAW by stalling
RF_BYPASS, 1, 1 = register file writes before reads in the same cycle, so a WB-stage match is no hazard
CNT_W, 16, width of the stall and flush performance counters

Ports:
cpu_clk  in  1  pipeline clock
cpu_rst  in  1  asynchronous, active-high reset
id_inst_i  in  32  instruction in the ID stage
id_valid_i  in  1  ID holds a real instruction (0 = bubble)
ex_br_taken_i  in  1  EX resolved a taken branch, JAL or JALR this cycle
id_sext_op_o  out  3  immediate type for the ID-stage extender (combinational)
stall_pc_o  out  1  hold the PC (combinational)
stall_ifid_o  out  1  hold the IF/ID register (combinational)
flush_ifid_o  out  1  clear the IF/ID register (combinational)
ex_rf_we_o  out  1  registered EX control: register-file write enable
ex_rf_wsel_o  out  2  registered: 0 ALU, 1 DRAM, 2 PC+4, 3 EXT
ex_alu_op_o  out  4  registered ALU operation
ex_alua_sel_o  out  1  registered: 0 rs1, 1 PC (AUIPC)
ex_alub_sel_o  out  1  registered: 0 rs2, 1 EXT
ex_ram_we_o  out  1  registered DRAM write enable
ex_br_o  out  3  registered {BTYPE, JAL, JALR}
ex_fwd_a_o  out  2  registered operand-A source: 0 RF, 1 EX/MEM, 2 MEM/WB, 3 WB
ex_fwd_b_o  out  2  same encoding, operand B
stall_cnt_o  out  CNT_W  stall cycles, saturating
flush_cnt_o  out  CNT_W  flush events, saturating

Behaviour:
- ALU op encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15.
- Illegal opcode decodes as a bubble: all write enables 0, br 0, ALU op ADD.
- Source usage:
  - rs1 is used by R, I, load, store, B and JALR.
  - rs2 is used by R, store and B.
  - Register x0 never matches.
- Trackers: EX, MEM and WB each hold {valid, rf_we, rd, is_load}.
  - Each cycle, WB<-MEM and MEM<-EX.
  - EX<-decoded ID, or a bubble when stalling, flushing or id_valid_i=0.
- Hazard match: a stage has valid & rf_we & rd!=0 & rd==a used rs.
- FWD_EN=1:
  - A match on EX with is_load gives a load-use hazard: stall exactly 1 cycle.
  - Otherwise the forward select is the youngest matching stage: EX=1, MEM=2, WB=3 (WB only when RF_BYPASS=0).
  - The select is computed in ID and registered alongside the bundle.
- FWD_EN=0:
  - Any match on EX or MEM stalls; a WB match also stalls when RF_BYPASS=0.
  - Forward selects are held at 0.
- Stall cycle:
  - stall_pc_o=1 and stall_ifid_o=1.
  - A bubble is inserted into EX; MEM and WB advance.
- Flush: ex_br_taken_i=1 asserts flush_ifid_o and loads a bubble into EX the next edge.
- Flush wins over stall: with both present, stall outputs are 0 and stall_cnt_o is not incremented.
- Counters:
  - stall_cnt_o increments once per stall cycle.
  - flush_cnt_o increments once per cycle with ex_br_taken_i=1.
  - Both saturate at all-ones.
- Latency: ID decode appears on the ex_* outputs one cycle later.
- Reset (asynchronous, any time):
  - Trackers are invalid.
  - The ex_* bundle is a bubble (rf_we 0, ram_we 0, br 0, alu_op 0, selects 0).
  - Counters are 0.
  - The combinational stall and flush outputs are 0 while cpu_rst is high.

Decomposition:
- The shared package ctrl_pkg holds:
  - ALU_OP, RF_WSEL, SEXT_OP, ALUA_SEL, ALUB_SEL and FWD_SEL constants.
  - Opcode constants.
  - The packed control-bundle typedef.
- One sub-module, inst_decoder: purely combinational opcode/funct3/funct7-to-bundle decode.
- Hazard tracking, registers and counters stay in ctrl_hazard_unit.

Test Plan:
- Load-use, FWD_EN=1: lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333). Required:
  - stall_pc_o=1 for exactly 1 cycle and stall_cnt_o=1.
  - A bubble in EX.
  - The add reaches EX with ex_fwd_a_o=2 and ex_fwd_b_o=0.
- ALU forward, FWD_EN=1: addi x1,x0,1 (0x00100093) then addi x2,x1,1 (0x00108113). Required:
  - No stall.
  - The second instruction in EX shows ex_fwd_a_o=1, ex_alub_sel_o=1, ex_alu_op_o=0.
- FWD_EN=0, RF_BYPASS=1, same pair. Required:
  - Exactly 2 stall cycles and stall_cnt_o=2.
  - ex_fwd_a_o=0.
- Flush during stall: the load-use pair with ex_br_taken_i=1 in the stall cycle. Required:
  - stall_pc_o=0 and flush_ifid_o=1.
  - Next cycle ex_rf_we_o=0; flush_cnt_o=1 and stall_cnt_o unchanged.
- x0 and illegal: addi x0,x0,0 (0x00000013) then add x6,x0,x0 (0x00000333). Required:
  - No stall and forward selects 0.
  - An illegal word 0xFFFFFFFF yields a bubble.
- Reset mid-stall: assert cpu_rst during the load-use stall. Required:
  - All ex_* outputs 0, counters 0, stall outputs 0, immediately (asynchronously).
